// File: rtl/axis_split_pkg.sv
// Shared definitions for the splitter scheduler and its CSR decode:
// status codes and the scheduler FSM state encoding.
package axis_split_pkg;

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_ERR     = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd2;
  localparam logic [1:0] STATUS_ABORT   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_KILL,
    ST_REPORT
  } sched_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with flush; the head entry is visible on
// pop_data whenever empty is low. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_COUNT);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Flush shares the reset path, so a push in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW + 1)'(1);
        2'b01:   count_reg <= count_reg - (AW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/axis_split_scheduler.sv
// Command-driven sequencer for the AXI-Stream packet splitter: queues sizes,
// starts one split per command, supervises it and returns a status record.
module axis_split_scheduler
  import axis_split_pkg::*;
#(
  parameter int PCKT_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int STAT_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [PCKT_WIDTH-1:0] cmd_pckt_size,
  input  logic                  pause,
  input  logic                  abort,
  output logic                  split_start,
  output logic [PCKT_WIDTH-1:0] split_pckt_size,
  output logic                  split_lock,
  output logic                  split_external_error,
  input  logic                  split_busy,
  input  logic                  split_complete,
  input  logic                  split_error,
  input  logic                  split_transmission,
  output logic                  status_valid,
  input  logic                  status_ready,
  output logic [1:0]            status_code,
  output logic [STAT_WIDTH-1:0] status_cycles,
  output logic                  idle
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_ENABLE = (TIMEOUT_CYCLES != 0);

  sched_state_t          state_reg, state_next;
  logic [1:0]            code_reg, code_next;
  logic [PCKT_WIDTH-1:0] size_reg;
  logic [STAT_WIDTH-1:0] cycles_reg;
  logic [WD_W-1:0]       wd_reg;
  logic                  start_reg;

  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [PCKT_WIDTH-1:0] fifo_data;
  logic                  wd_expire;
  logic                  kill_pulse;

  sync_fifo #(
    .WIDTH (PCKT_WIDTH),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (cmd_valid),
    .push_data (cmd_pckt_size),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Expiry fires in the cycle the counter would step onto TIMEOUT_CYCLES.
  assign wd_expire = WD_ENABLE && !pause && !split_transmission && (wd_reg == WD_LAST);

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    fifo_pop   = 1'b0;
    kill_pulse = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !abort) begin
          fifo_pop = 1'b1;
          if (fifo_data == '0) begin
            state_next = ST_REPORT;
            code_next  = STATUS_ERR;
          end else begin
            state_next = ST_START;
            code_next  = STATUS_OK;
          end
        end
      end
      ST_START: begin
        if (abort) begin
          kill_pulse = 1'b1;
          state_next = ST_KILL;
          code_next  = STATUS_ABORT;
        end else if (split_busy) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (split_complete) begin
          state_next = ST_REPORT;
          code_next  = STATUS_OK;
        end else if (split_error) begin
          state_next = ST_REPORT;
          code_next  = STATUS_ERR;
        end else if (abort) begin
          kill_pulse = 1'b1;
          state_next = ST_KILL;
          code_next  = STATUS_ABORT;
        end else if (wd_expire) begin
          kill_pulse = 1'b1;
          state_next = ST_KILL;
          code_next  = STATUS_TIMEOUT;
        end
      end
      ST_KILL: begin
        if (split_error) state_next = ST_REPORT;
      end
      ST_REPORT: begin
        if (status_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      code_reg   <= STATUS_OK;
      size_reg   <= '0;
      cycles_reg <= '0;
      wd_reg     <= '0;
      start_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      code_reg  <= code_next;
      // Start is registered and dropped on the edge the FSM leaves START.
      start_reg <= (state_reg == ST_START) && (state_next == ST_START);

      if (fifo_pop) begin
        size_reg <= fifo_data;
      end

      if (fifo_pop) begin
        cycles_reg <= '0;
      end else if ((state_reg == ST_START || state_reg == ST_RUN) && (cycles_reg != '1)) begin
        cycles_reg <= cycles_reg + STAT_WIDTH'(1);
      end

      if (state_reg != ST_RUN || split_transmission || !WD_ENABLE) begin
        wd_reg <= '0;
      end else if (!pause) begin
        wd_reg <= wd_reg + WD_W'(1);
      end
    end
  end

  assign cmd_ready            = !fifo_full;
  assign split_start          = start_reg;
  assign split_pckt_size      = size_reg;
  assign split_lock           = pause;
  assign split_external_error = kill_pulse;
  assign status_valid         = (state_reg == ST_REPORT);
  assign status_code          = code_reg;
  assign status_cycles        = cycles_reg;
  assign idle                 = (state_reg == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_axis_split_scheduler.sv
// Bench for axis_split_scheduler: a behavioural splitter model answers the
// control pins, and a scoreboard checks each returned status record.
module tb_axis_split_scheduler;
  import axis_split_pkg::*;

  localparam int M_OK = 0, M_ERR = 1, M_HANG = 2;

  typedef struct {
    logic [31:0] size;
    int          len;
    int          mode;
    logic [1:0]  exp_code;
  } cmd_t;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_pckt_size;
  logic        pause, abort;
  logic        split_start, split_lock, split_external_error;
  logic [31:0] split_pckt_size;
  logic        split_busy, split_complete, split_error, split_transmission;
  logic        status_valid, status_ready;
  logic [1:0]  status_code;
  logic [31:0] status_cycles;
  logic        idle;

  axis_split_scheduler #(
    .PCKT_WIDTH(32), .CMD_DEPTH(4), .STAT_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pckt_size(cmd_pckt_size),
    .pause(pause), .abort(abort),
    .split_start(split_start), .split_pckt_size(split_pckt_size),
    .split_lock(split_lock), .split_external_error(split_external_error),
    .split_busy(split_busy), .split_complete(split_complete),
    .split_error(split_error), .split_transmission(split_transmission),
    .status_valid(status_valid), .status_ready(status_ready),
    .status_code(status_code), .status_cycles(status_cycles), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0;
  cmd_t push_q[$];
  cmd_t cur_cmd;
  int   hs_q[$], st_q[$];
  bit   pushed, rnd_mode;
  // splitter model and per-operation observations
  bit   m_busy;
  int   m_left, m_mode, start_cnt, busy_edge, ext_span;
  bit   start_seen, res_valid, ext_seen;
  int   s_edge, res_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_code_of(input logic [31:0] size, input int mode);
    if (size == 0)     return STATUS_ERR;
    if (mode == M_OK)  return STATUS_OK;
    if (mode == M_ERR) return STATUS_ERR;
    return STATUS_TIMEOUT;
  endfunction

  task automatic tick();
    logic p_start, p_ext, p_abort, p_lock, p_sv, p_sr, p_cv, p_cr, p_cpl, p_err, p_rst;
    logic [1:0]  p_code;
    logic [31:0] p_cycles;
    cmd_t rec;
    if (rnd_mode) begin
      pause        = ($urandom_range(0, 7) == 0);
      status_ready = $urandom_range(0, 1) != 0;
    end
    #2;
    p_start = split_start; p_ext = split_external_error; p_abort = abort;
    p_lock = split_lock; p_sv = status_valid; p_sr = status_ready;
    p_cv = cmd_valid; p_cr = cmd_ready; p_cpl = split_complete; p_err = split_error;
    p_rst = rst; p_code = status_code; p_cycles = status_cycles;
    if (!p_rst) begin
      if (start_seen && !res_valid && (p_cpl || p_err || p_ext)) begin
        res_valid  = 1'b1;
        res_cycles = cyc + 1 - s_edge + 1;
      end
      if (p_sv && p_sr) begin
        if (push_q.size() == 0) begin
          chk("status_unexpected", 1, 0);
        end else begin
          rec = push_q.pop_front();
          chk("status_code", p_code, rec.exp_code);
          if (rec.size == 0) begin
            chk("size0_cycles", p_cycles, 0);
            chk("size0_no_start", start_seen, 0);
          end else begin
            chk("result_seen", res_valid, 1);
            chk("status_cycles", p_cycles, res_cycles);
          end
          $display("status size=%0d code=%0d cycles=%0d", rec.size, p_code, p_cycles);
        end
        hs_q.push_back(cyc + 1);
        start_seen = 0; res_valid = 0; ext_seen = 0;
      end
      if (p_cv && p_cr && !p_abort) begin
        push_q.push_back(cur_cmd);
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    split_complete = 1'b0;
    split_error    = 1'b0;
    if (p_rst) begin
      m_busy = 0; push_q.delete(); start_seen = 0; res_valid = 0; ext_seen = 0;
    end else if (p_ext) begin
      split_error = 1'b1;
      m_busy = 0;
    end else if (m_busy && !p_lock) begin
      if (m_mode != M_HANG) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          if (m_mode == M_ERR) split_error = 1'b1;
          else                 split_complete = 1'b1;
        end
      end
    end else if (!m_busy && p_start && !p_lock) begin
      m_busy = 1; start_cnt++; busy_edge = cyc;
      if (push_q.size() > 0) begin
        m_left = push_q[0].len; m_mode = push_q[0].mode;
        chk("size_at_start", split_pckt_size, push_q[0].size);
      end else begin
        m_left = 1; m_mode = M_OK;
        chk("start_without_cmd", 1, 0);
      end
    end
    split_busy         = m_busy;
    split_transmission = m_busy && (m_mode != M_HANG) && !p_lock;
    if (!p_rst) begin
      if (split_start && !start_seen) begin
        start_seen = 1; s_edge = cyc; st_q.push_back(cyc);
      end
      if (split_external_error && !ext_seen) begin
        ext_seen = 1; ext_span = cyc - busy_edge;
      end
      if (p_sv && !p_sr) begin
        chk("status_hold_valid", status_valid, 1);
        chk("status_hold_code", status_code, p_code);
        chk("status_hold_cycles", status_cycles, p_cycles);
      end
      if (split_busy && push_q.size() > 0) chk("size_stable", split_pckt_size, push_q[0].size);
    end
  endtask

  task automatic push_cmd(input cmd_t c);
    cur_cmd = c; cmd_pckt_size = c.size; cmd_valid = 1'b1; pushed = 1'b0;
    for (int i = 0; i < 300 && !pushed; i++) tick();
    cmd_valid = 1'b0;
    chk("push_accept", pushed, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && push_q.size() != 0; i++) tick();
    chk("drain", push_q.size(), 0);
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && !m_busy; i++) tick();
    chk("busy_reached", m_busy, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start"}, split_start, 0);
    chk({tag, "_size"}, split_pckt_size, 0);
    chk({tag, "_ext"}, split_external_error, 0);
    chk({tag, "_lock"}, split_lock, 0);
    chk({tag, "_sv"}, status_valid, 0);
    chk({tag, "_code"}, status_code, 0);
    chk({tag, "_cycles"}, status_cycles, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_idle"}, idle, 1);
  endtask

  cmd_t vec[6];

  initial begin
    int n, sc;
    rst = 1; cmd_valid = 0; cmd_pckt_size = 0; pause = 0; abort = 0; status_ready = 1;
    split_busy = 0; split_complete = 0; split_error = 0; split_transmission = 0;
    rnd_mode = 0; m_busy = 0; start_cnt = 0; start_seen = 0; res_valid = 0; ext_seen = 0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 0;
    tick();

    // Push-to-start latency, then two back-to-back operations.
    hs_q.delete(); st_q.delete();
    push_cmd('{32'd4, 5, M_OK, STATUS_OK});
    n = cyc;
    chk("lat_start_n", split_start, 0);
    tick();
    chk("lat_start_n1", split_start, 0);
    chk("lat_size_n1", split_pckt_size, 4);
    tick();
    chk("lat_start_n2", split_start, 1);
    push_cmd('{32'd8, 3, M_OK, STATUS_OK});
    wait_done(200);
    chk("two_starts", st_q.size(), 2);
    chk("first_start_edge", st_q.size() > 0 ? st_q[0] - n : -1, 2);
    chk("status_to_start", (st_q.size() > 1 && hs_q.size() > 0) ? st_q[1] - hs_q[0] : -1, 2);

    // Table-driven commands: zero size, normal, error, timeout, extremes.
    vec[0] = '{32'd0,          0, M_OK,   STATUS_ERR};
    vec[1] = '{32'd3,          4, M_OK,   STATUS_OK};
    vec[2] = '{32'd12,         3, M_ERR,  STATUS_ERR};
    vec[3] = '{32'd5,          0, M_HANG, STATUS_TIMEOUT};
    vec[4] = '{32'd1,          1, M_OK,   STATUS_OK};
    vec[5] = '{32'hFFFF_FFFF,  6, M_OK,   STATUS_OK};
    sc = start_cnt;
    for (int i = 0; i < 6; i++) push_cmd(vec[i]);
    wait_done(400);
    chk("table_starts", start_cnt - sc, 5);

    // Watchdog spacing: pulse on the 16th run cycle without transmission.
    push_cmd('{32'd5, 0, M_HANG, STATUS_TIMEOUT});
    wait_done(200);
    chk("timeout_span", ext_span, 16);

    // Long pause in RUN must not trip the watchdog.
    push_cmd('{32'd7, 10, M_OK, STATUS_OK});
    wait_busy(50);
    tick(); tick();
    pause = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("pause_lock", split_lock, 1);
      chk("pause_no_kill", split_external_error, 0);
    end
    pause = 0;
    wait_done(200);

    // Abort during RUN with two commands queued behind it.
    push_cmd('{32'd21, 0, M_HANG, STATUS_TIMEOUT});
    push_cmd('{32'd22, 4, M_OK, STATUS_OK});
    push_cmd('{32'd23, 4, M_OK, STATUS_OK});
    wait_busy(50);
    tick(); tick(); tick();
    abort = 1;
    #2;
    chk("abort_kill_pulse", split_external_error, 1);
    tick();
    abort = 0;
    if (push_q.size() > 0) begin
      push_q[0].exp_code = STATUS_ABORT;
      while (push_q.size() > 1) void'(push_q.pop_back());
    end
    tick();
    chk("abort_pulse_single", split_external_error, 0);
    sc = start_cnt;
    wait_done(100);
    tick();
    chk("abort_idle", idle, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_start", start_cnt - sc, 0);
    chk("abort_idle_late", idle, 1);

    // Status held in REPORT while status_ready is low.
    status_ready = 0;
    push_cmd('{32'd9, 2, M_OK, STATUS_OK});
    push_cmd('{32'd6, 2, M_OK, STATUS_OK});
    for (int i = 0; i < 100 && !status_valid; i++) tick();
    chk("report_reached", status_valid, 1);
    sc = start_cnt;
    for (int i = 0; i < 10; i++) tick();
    chk("report_no_start", start_cnt - sc, 0);
    status_ready = 1;
    wait_done(200);

    // Randomised traffic with random pause and status back-pressure.
    rnd_mode = 1;
    for (int i = 0; i < 40; i++) begin
      cmd_t c;
      int r;
      r      = $urandom_range(0, 9);
      c.size = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      c.len  = $urandom_range(1, 12);
      c.mode = (r < 6) ? M_OK : (r < 8) ? M_ERR : M_HANG;
      c.exp_code = exp_code_of(c.size, c.mode);
      push_cmd(c);
      for (int k = $urandom_range(0, 6); k > 0; k--) tick();
    end
    rnd_mode = 0; pause = 0; status_ready = 1;
    wait_done(2000);

    // Reset in the middle of a run.
    push_cmd('{32'd10, 0, M_HANG, STATUS_TIMEOUT});
    wait_busy(50);
    tick(); tick();
    rst = 1;
    tick();
    check_reset_outputs("midrst");
    rst = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_split_scheduler.md
# axis_split_scheduler

Command-driven controller that sequences the AXI-Stream packet splitter. It queues packet-size commands and starts one splitter operation per command, holding size and start stable for the splitter's latch window. It supervises the run with a pause, an abort and a no-progress watchdog, and returns one status record per command. It sits between the host/CSR command path and the splitter's control and interrupt pins; the stream datapath is not touched.

## Interface
- `PCKT_WIDTH`, 32, width of packet-size field (matches splitter)
- `CMD_DEPTH`, 4, command FIFO depth (power of two, ≥2)
- `STAT_WIDTH`, 32, width of elapsed-cycle counter in status
- `TIMEOUT_CYCLES`, 1024, max consecutive no-transmission cycles while running; 0 disables watchdog

Ports:
- `clk` in 1 — single clock
- `rst` in 1 — synchronous, active-high reset
- `cmd_valid` in 1 / `cmd_ready` out 1 / `cmd_pckt_size` in PCKT_WIDTH — command push (valid/ready)
- `pause` in 1 — freeze splitter (drives lock) and watchdog
- `abort` in 1 — level-sampled abort request
- `split_start` out 1 — to splitter operation_start
- `split_pckt_size` out PCKT_WIDTH — to splitter pckt_size
- `split_lock` out 1 — to splitter lock
- `split_external_error` out 1 — to splitter external_error
- `split_busy`, `split_complete`, `split_error`, `split_transmission` in 1 each — splitter interrupt outputs
- `status_valid` out 1 / `status_ready` in 1 — status handshake
- `status_code` out 2 — 0 OK, 1 ERR, 2 TIMEOUT, 3 ABORT
- `status_cycles` out STAT_WIDTH — cycles from start assertion to terminal flag, saturating
- `idle` out 1 — FSM in IDLE and FIFO empty

## Operation
- Command FIFO: `cmd_ready` = not full. Push on valid&ready. Show-ahead read.
- FSM states: IDLE, START, RUN, KILL, REPORT.
- IDLE: FIFO non-empty → pop and register size into `split_pckt_size`.
  - Size 0: go directly to REPORT with ERR; splitter is not started.
  - Otherwise go to START.
- START: `split_start`=1, held until `split_busy`=1, then go to RUN. `split_pckt_size` stays constant from START through REPORT.
- RUN: `split_start`=0.
  - `split_complete` → REPORT, OK.
  - `split_error` without own kill → REPORT, ERR (splitter non-divisible or last error).
- Watchdog, active in RUN only:
  - Counter clears on `split_transmission`; holds while `pause`; increments otherwise.
  - On reaching TIMEOUT_CYCLES: `split_external_error`=1 for one cycle, go to KILL, code TIMEOUT.
- Abort in START or RUN: `split_external_error` one-cycle pulse, flush FIFO, go to KILL, code ABORT.
- Abort in IDLE: flush FIFO only, no status.
- Abort in REPORT: flush FIFO only; the pending status is unchanged.
- KILL: wait for `split_error`, then go to REPORT with the latched code.
- REPORT: `status_valid`=1, `status_code`/`status_cycles` held stable until `status_ready`. On handshake return to IDLE.
- `split_lock` = `pause` (combinational pass-through).
- Cycle counter: clears on entry to START; +1 per cycle; saturates at all-ones; frozen in KILL/REPORT.
- Reset values: all outputs 0 except `cmd_ready`=1 and `idle`=1; FIFO empty; FSM in IDLE.
- Reset mid-operation: returns to IDLE at once. The splitter shares `rst`, so both restart together.

## Timing
- Push at edge N into empty FIFO while idle → pop at edge N+1 → `split_start` high from edge N+2.
- Splitter raises `split_busy` one cycle after sampling start, so `split_start` is high for ≥1 cycle and normally 2.
- Simultaneous events in RUN, priority order: `split_complete` > abort > timeout.
  - An abort or timeout arriving in the same cycle as `split_complete` is ignored, except that an abort still flushes the FIFO.
- `split_error` in the same cycle as watchdog expiry → ERR; no kill pulse is issued.
- `pause` in START has no effect on `split_start`: the splitter's lock defers the start, and the start is held until it is accepted.
- Push and flush in the same cycle: the flush wins and the pushed command is dropped.
- Status-to-next-start: status handshake at edge M → next `split_start` earliest at edge M+2.

## Structure
- Package `axis_split_pkg`:
  - status code constants (OK/ERR/TIMEOUT/ABORT);
  - FSM state enum/localparams;
  - shared by the scheduler and CSR decode.
- Sub-module `sync_fifo`: show-ahead, synchronous, flush input, parameterised width/depth; used for the command queue.
- Watchdog and cycle counters stay inline.

## Test plan
- Push sizes 4, 8 → two starts in order, `split_pckt_size` stable per op. Model completes → two statuses OK, `status_cycles` matches model latency.
- Push size 0 → no `split_start`; status ERR next cycles; following command (size 3) runs normally.
- TIMEOUT_CYCLES=16, model busy with no transmission → `split_external_error` pulse at 16th idle cycle. Model error → status TIMEOUT.
- 3 commands queued, abort during first RUN → kill pulse, status ABORT, FIFO empty, no further starts, `idle`=1 after handshake.
- Pause 50 cycles mid-RUN with TIMEOUT_CYCLES=16 → `split_lock`=1, no timeout; resume → complete → OK.
- `status_ready` held low 10 cycles in REPORT → status fields stable, no new start. Assert `rst` during RUN → all outputs at reset values next cycle.
